// File: rtl/stopwatch_sequencer.sv
// Stopwatch front-end: button synchronise/debounce, run/pause/lap/reset FSM,
// and the prescaler that produces the 1 Hz count strobe for the counter datapath.
module stopwatch_sequencer #(
  parameter int TICK_DIV  = 100000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       count_en,
  output logic       count_rst,
  output logic       lap_latch,
  output logic       lap_hold,
  output logic [1:0] status
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_LAP    = 2'b11
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_lr, btn_ss};

  // Index 0 is start/stop, index 1 is lap/reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_q;
      logic          sync2_q;
      logic          level_q;
      logic          level_d;
      logic          level_prev_q;
      logic [DW-1:0] cnt_q;
      logic [DW-1:0] cnt_d;

      // Count consecutive disagreeing samples; any agreeing sample clears the run.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
          cnt_q        <= '0;
        end else begin
          sync1_q      <= btn_raw[gi];
          sync2_q      <= sync1_q;
          level_q      <= level_d;
          level_prev_q <= level_q;
          cnt_q        <= cnt_d;
        end
      end

      assign press[gi] = level_q & ~level_prev_q;
    end
  endgenerate

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;
  logic          count_rst_q;
  logic          count_rst_d;
  logic          lap_latch_q;
  logic          lap_latch_d;
  logic          lap_hold_q;
  logic          lap_hold_d;
  logic          active;
  logic          ev_ss;
  logic          ev_lr;

  assign ev_ss  = press[0];
  assign ev_lr  = press[1];
  assign active = (state_q == S_RUN) || (state_q == S_LAP);

  always_comb begin
    state_d     = state_q;
    count_rst_d = 1'b0;
    lap_latch_d = 1'b0;
    lap_hold_d  = lap_hold_q;
    psc_d       = psc_q;
    if (active) begin
      psc_d = (psc_q == PSC_MAX) ? '0 : psc_q + PW'(1);
    end

    // Start/stop has priority; a simultaneous lap/reset press is discarded.
    if (ev_ss) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          psc_d   = '0;
        end
        S_RUN:    state_d = S_PAUSED;
        S_LAP: begin
          state_d    = S_PAUSED;
          lap_hold_d = 1'b0;
        end
        S_PAUSED: state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end else if (ev_lr) begin
      case (state_q)
        S_IDLE:   count_rst_d = 1'b1;
        S_RUN: begin
          state_d     = S_LAP;
          lap_latch_d = 1'b1;
          lap_hold_d  = 1'b1;
        end
        S_LAP: begin
          state_d    = S_RUN;
          lap_hold_d = 1'b0;
        end
        S_PAUSED: begin
          state_d     = S_IDLE;
          count_rst_d = 1'b1;
          psc_d       = '0;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      psc_q       <= '0;
      count_rst_q <= 1'b0;
      lap_latch_q <= 1'b0;
      lap_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      psc_q       <= psc_d;
      count_rst_q <= count_rst_d;
      lap_latch_q <= lap_latch_d;
      lap_hold_q  <= lap_hold_d;
    end
  end

  assign count_en  = active && (psc_q == PSC_MAX);
  assign count_rst = count_rst_q;
  assign lap_latch = lap_latch_q;
  assign lap_hold  = lap_hold_q;
  assign status    = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Scoreboard bench for stopwatch_sequencer: a behavioural model predicts every
// cycle's outputs into a queue, and a monitor compares them against the DUT.
module tb_stopwatch_sequencer;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       count_en;
  logic       count_rst;
  logic       lap_latch;
  logic       lap_hold;
  logic [1:0] status;

  stopwatch_sequencer #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .count_en  (count_en),
    .count_rst (count_rst),
    .lap_latch (lap_latch),
    .lap_hold  (lap_hold),
    .status    (status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] status;
    logic       count_en;
    logic       count_rst;
    logic       lap_latch;
    logic       lap_hold;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model: status 0 idle, 1 running, 2 paused, 3 lap.
  int m_state;
  int m_active_cnt;   // active edges since last prescaler clear
  bit m_hold;
  bit m_lvl  [2];
  bit m_lvlp [2];
  bit raw_h  [2][$];  // raw button samples since reset, one per edge
  bit syn_h  [2][$];  // synchronised sample seen at each edge since reset

  task automatic model_edge(input bit ss, input bit lr, input bit r);
    exp_t e;
    bit   ev_ss, ev_lr, act, crst, latch, flip, syn;
    bit   btn [2];
    int   n;
    e = '0;
    if (r) begin
      m_state = 0;
      m_active_cnt = 0;
      m_hold = 0;
      for (int b = 0; b < 2; b++) begin
        m_lvl[b] = 0;
        m_lvlp[b] = 0;
        raw_h[b].delete();
        syn_h[b].delete();
      end
      exp_q.push_back(e);
      return;
    end
    ev_ss = m_lvl[0] && !m_lvlp[0];
    ev_lr = m_lvl[1] && !m_lvlp[1];
    act   = (m_state == 1) || (m_state == 3);
    crst  = 0;
    latch = 0;
    if (act) m_active_cnt++;
    if (ev_ss) begin
      case (m_state)
        0: begin m_state = 1; m_active_cnt = 0; end
        1: m_state = 2;
        3: begin m_state = 2; m_hold = 0; end
        default: m_state = 1;
      endcase
    end else if (ev_lr) begin
      case (m_state)
        0: crst = 1;
        1: begin m_state = 3; latch = 1; m_hold = 1; end
        3: begin m_state = 1; m_hold = 0; end
        default: begin m_state = 0; crst = 1; m_active_cnt = 0; end
      endcase
    end
    // A level flips once the last DB synchronised samples all disagree with it.
    btn[0] = ss;
    btn[1] = lr;
    for (int b = 0; b < 2; b++) begin
      raw_h[b].push_back(btn[b]);
      n = raw_h[b].size();
      syn = (n >= 3) ? raw_h[b][n-3] : 1'b0;
      syn_h[b].push_back(syn);
      flip = (syn_h[b].size() >= DB);
      for (int k = 0; k < DB && flip; k++)
        if (syn_h[b][syn_h[b].size()-1-k] == m_lvl[b]) flip = 0;
      m_lvlp[b] = m_lvl[b];
      if (flip) m_lvl[b] = !m_lvl[b];
    end
    e.status    = 2'(m_state);
    e.count_en  = ((m_state == 1) || (m_state == 3)) && (m_active_cnt % TD == TD - 1);
    e.count_rst = crst;
    e.lap_latch = latch;
    e.lap_hold  = m_hold;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit ss, input bit lr, input bit r);
    btn_ss = ss;
    btn_lr = lr;
    rst    = r;
    model_edge(ss, lr, r);
    @(negedge clk);
  endtask

  task automatic hold(input bit ss, input bit lr, input int cycles);
    for (int i = 0; i < cycles; i++) step(ss, lr, 1'b0);
  endtask

  // Monitor: every clock produces one output set, compared against the queue head.
  initial begin
    exp_t want;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cycle%0d no_expectation: got status=%b, want a queued prediction", cycle, status);
      end else begin
        want = exp_q.pop_front();
        if ({status, count_en, count_rst, lap_latch, lap_hold} !== want) begin
          errors++;
          $display("FAIL cycle%0d outputs: got status=%b en=%b crst=%b latch=%b hold=%b, want status=%b en=%b crst=%b latch=%b hold=%b",
                   cycle, status, count_en, count_rst, lap_latch, lap_hold,
                   want.status, want.count_en, want.count_rst, want.lap_latch, want.lap_hold);
        end
      end
    end
  end

  initial begin
    // Reset with both buttons held: ss wins once debounced, lr is dropped.
    step(1, 1, 1);
    step(1, 1, 1);
    hold(1, 1, 10);
    hold(0, 0, 10);
    // Clean start from IDLE and count_en cadence.
    step(0, 0, 1);
    hold(0, 0, 3);
    hold(1, 0, 10);
    hold(0, 0, 14);
    // Short glitch: no event.
    hold(1, 0, 2);
    hold(0, 0, 6);
    // Lap in and out.
    hold(0, 1, 6);
    hold(0, 0, 9);
    hold(0, 1, 6);
    hold(0, 0, 7);
    // Pause, wait, resume.
    hold(1, 0, 6);
    hold(0, 0, 20);
    hold(1, 0, 6);
    hold(0, 0, 11);
    // Pause then lap/reset to IDLE, then restart.
    hold(1, 0, 6);
    hold(0, 0, 8);
    hold(0, 1, 6);
    hold(0, 0, 8);
    hold(1, 0, 6);
    hold(0, 0, 12);
    // Randomised segments, including bounces and the odd mid-debounce reset.
    for (int s = 0; s < 150; s++) begin
      int len;
      bit ss, lr;
      len = $urandom_range(1, 12);
      ss  = ($urandom_range(0, 2) == 0);
      lr  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < $urandom_range(1, 2); i++) step(ss, lr, 1'b1);
      end
      hold(ss, lr, len);
    end
    hold(0, 0, 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unconsumed predictions, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_sequencer.md
Name: stopwatch_sequencer

Overview:
Front-end controller for the stopwatch counter datapath. It synchronises and debounces two raw push-buttons, runs the run/pause/lap/reset state machine, and divides the system clock into a 1 Hz count strobe. It drives the seconds/minutes counters' enable and clear inputs, plus lap-freeze controls for the display path.

Parameters:
TICK_DIV, 100000000, system clock cycles per count strobe; must be >= 2.
DB_CYCLES, 1000000, consecutive stable samples needed to accept a button level change; must be >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
btn_ss  input  1  raw start/stop button, asynchronous, active-high.
btn_lr  input  1  raw lap/reset button, asynchronous, active-high.
count_en  output  1  one-cycle strobe that advances the seconds counter.
count_rst  output  1  one-cycle pulse that clears the seconds/minutes counters.
lap_latch  output  1  one-cycle pulse that captures the current time into the display lap register.
lap_hold  output  1  level signal; display shows the lap register while high.
status  output  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 LAP.

Behaviour:
- Reset (rst high at an edge): state IDLE; prescaler, sync flops, debounce counters and debounced levels all 0. Outputs: status 00, count_en 0, count_rst 0, lap_latch 0, lap_hold 0. Reset mid-debounce discards the partial count.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounced level flips only after the synchronised level has differed from it for DB_CYCLES consecutive edges. Any agreeing sample restarts the count.
  - Press event is a one-cycle pulse on each rising edge of the debounced level. Releases generate no event.
  - Latency: for a clean press, the event is high in cycle 2+DB_CYCLES after the first edge that samples btn high. State updates on the next edge.
- FSM (state and registered outputs update on the edge where an event is high):
  - IDLE: ss -> RUNNING, prescaler cleared to 0. lr -> stay IDLE, count_rst pulse.
  - RUNNING: ss -> PAUSED. lr -> LAP, lap_latch pulse, lap_hold=1.
  - LAP: ss -> PAUSED, lap_hold=0. lr -> RUNNING, lap_hold=0.
  - PAUSED: ss -> RUNNING, prescaler NOT cleared so the fractional second is preserved. lr -> IDLE, count_rst pulse, prescaler cleared.
  - Simultaneous ss and lr events: ss is taken and lr is dropped, with no pending request kept.
- Prescaler: counts 0..TICK_DIV-1 and wraps. It advances on every edge where the current state is RUNNING or LAP, and holds otherwise. Width is clog2(TICK_DIV).
- count_en = (state is RUNNING or LAP) AND (prescaler == TICK_DIV-1). It is decoded from registers with no extra latency. Counting continues in LAP.
- Pause coinciding with the wrap cycle: count_en is still 1 in that cycle (state is still RUNNING), and the prescaler wraps to 0 on the same edge.
- count_rst and lap_latch are registered. They are high for exactly one cycle, the first cycle in which status shows the new state (or the unchanged IDLE state for an IDLE lr).
- count_en is never high in the same cycle as count_rst.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
1. rst high for 2 cycles with both buttons held high -> status 00, all outputs 0. After rst drops, the held buttons produce events after 5 cycles: ss wins -> RUNNING; lr is not seen.
2. IDLE, clean btn_ss press held 10 cycles -> status 01 on the 6th edge after the first high sample. count_en high on the 4th, 8th, 12th... RUNNING cycles.
3. btn_ss high for 2 cycles only, then low -> no event, status unchanged, debounce count restarts.
4. RUNNING, press btn_lr -> status 11, lap_latch high 1 cycle, lap_hold 1, count_en cadence unbroken. Press btn_lr again -> status 01, lap_hold 0.
5. Pause after exactly 6 RUNNING cycles (prescaler=2), wait 20 cycles with no count_en, resume -> first count_en on the 2nd RUNNING cycle.
6. PAUSED, press btn_lr -> status 00, count_rst high exactly 1 cycle, prescaler 0. Next ss press -> first count_en on the 4th RUNNING cycle.
